// File: rtl/hazard_ctrl_pkg.sv
// Shared constants and FSM encoding for the issue-side hazard controller.
package hazard_ctrl_pkg;

  localparam int unsigned REG_AW     = 5;
  localparam int unsigned MULDIV_LAT = 4;
  localparam int unsigned CNT_W      = 4;

  typedef enum logic [1:0] {
    HC_IDLE = 2'b00,
    HC_BUSY = 2'b01,
    HC_DONE = 2'b10
  } hc_state_e;

endpackage

// File: rtl/md_scoreboard.sv
// One-deep mul/div scoreboard: tracks the in-flight op's destination, counts its latency
// and flags RAW/WAW/structural hazards against the instruction in ID.
module md_scoreboard
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MulDivLat = 4,
  parameter int unsigned RegAw     = 5
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             issue_valid_i,
  input  logic [RegAw-1:0] rs1_addr_i,
  input  logic [RegAw-1:0] rs2_addr_i,
  input  logic             rs1_re_i,
  input  logic             rs2_re_i,
  input  logic [RegAw-1:0] rd_addr_i,
  input  logic             rd_we_i,
  input  logic             is_muldiv_i,
  input  logic             mem_busy_i,
  input  logic             issue_i,
  output logic             md_hazard_o,
  output logic             md_busy_o,
  output logic             md_done_o,
  output logic [RegAw-1:0] md_rd_addr_o
);

  hc_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [RegAw-1:0] md_rd_q, md_rd_d;
  logic             md_wr_q, md_wr_d;

  logic             raw;
  logic             waw;

  // Compare the ID instruction against the in-flight entry; only meaningful while BUSY.
  always_comb begin
    raw = 1'b0;
    waw = 1'b0;
    if (md_wr_q && (md_rd_q != '0)) begin
      raw = (rs1_re_i && (rs1_addr_i == md_rd_q)) || (rs2_re_i && (rs2_addr_i == md_rd_q));
    end
    waw = rd_we_i && (rd_addr_i == md_rd_q) && (md_rd_q != '0);
    md_hazard_o = issue_valid_i && (state_q == HC_BUSY) && (raw || waw || is_muldiv_i);
  end

  // Next-state: DONE behaves like IDLE for a new issue so back-to-back ops have no gap.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    md_rd_d = md_rd_q;
    md_wr_d = md_wr_q;
    unique case (state_q)
      HC_IDLE: begin
        if (issue_i) begin
          state_d = HC_BUSY;
          cnt_d   = CNT_W'(MulDivLat - 1);
          md_rd_d = rd_addr_i;
          md_wr_d = rd_we_i && (rd_addr_i != '0);
        end
      end
      HC_BUSY: begin
        if (mem_busy_i) begin
          cnt_d = cnt_q;
        end else if (cnt_q != CNT_W'(1)) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          state_d = HC_DONE;
        end
      end
      HC_DONE: begin
        if (issue_i) begin
          state_d = HC_BUSY;
          cnt_d   = CNT_W'(MulDivLat - 1);
          md_rd_d = rd_addr_i;
          md_wr_d = rd_we_i && (rd_addr_i != '0);
        end else begin
          state_d = HC_IDLE;
          cnt_d   = '0;
          md_rd_d = '0;
          md_wr_d = 1'b0;
        end
      end
      default: begin
        state_d = HC_IDLE;
        cnt_d   = '0;
        md_rd_d = '0;
        md_wr_d = 1'b0;
      end
    endcase
  end

  // State, counter and scoreboard entry registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= HC_IDLE;
      cnt_q   <= '0;
      md_rd_q <= '0;
      md_wr_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      md_rd_q <= md_rd_d;
      md_wr_q <= md_wr_d;
    end
  end

  // Status outputs decode straight from registered state.
  always_comb begin
    md_busy_o    = (state_q == HC_BUSY);
    md_done_o    = (state_q == HC_DONE);
    md_rd_addr_o = '0;
    if ((state_q == HC_BUSY) || (state_q == HC_DONE)) begin
      md_rd_addr_o = md_rd_q;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Issue-side hazard controller: detects load-use and mul/div hazards, freezes IF/ID and
// injects an EX bubble; a memory wait freezes the whole pipe without a bubble.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULDIV_LAT = hazard_ctrl_pkg::MULDIV_LAT,
  parameter int unsigned REG_AW     = hazard_ctrl_pkg::REG_AW
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              IssueValidIn,
  input  logic [REG_AW-1:0] Rs1AddrIdIn,
  input  logic [REG_AW-1:0] Rs2AddrIdIn,
  input  logic              Rs1ReadEnableIn,
  input  logic              Rs2ReadEnableIn,
  input  logic [REG_AW-1:0] RdAddrIdIn,
  input  logic              RdWriteEnableIdIn,
  input  logic              IsMulDivIdIn,
  input  logic [REG_AW-1:0] RdAddrExIn,
  input  logic              RdWriteEnableExIn,
  input  logic              MemReadExIn,
  input  logic              MemBusyIn,
  input  logic              FlushIn,
  output logic              StallIfOut,
  output logic              StallIdOut,
  output logic              BubbleExOut,
  output logic              MdBusyOut,
  output logic              MdDoneOut,
  output logic [REG_AW-1:0] MdRdAddrOut
);

  logic load_use;
  logic md_hazard;
  logic hazard;
  logic stall;
  logic issue;

  // Load-use detection and stall/bubble muxing; outputs are forced low while in reset.
  always_comb begin
    load_use = 1'b0;
    if (IssueValidIn && MemReadExIn && RdWriteEnableExIn && (RdAddrExIn != '0)) begin
      load_use = (Rs1ReadEnableIn && (Rs1AddrIdIn == RdAddrExIn)) ||
                 (Rs2ReadEnableIn && (Rs2AddrIdIn == RdAddrExIn));
    end
    hazard      = (load_use || md_hazard) && !FlushIn;
    stall       = hazard || MemBusyIn;
    issue       = IssueValidIn && IsMulDivIdIn && !stall && !FlushIn;
    StallIfOut  = Rst && stall;
    StallIdOut  = Rst && stall;
    BubbleExOut = Rst && hazard && !MemBusyIn;
  end

  md_scoreboard #(
    .MulDivLat(MULDIV_LAT),
    .RegAw    (REG_AW)
  ) u_md_scoreboard (
    .clk_i        (Clk),
    .rst_ni       (Rst),
    .issue_valid_i(IssueValidIn),
    .rs1_addr_i   (Rs1AddrIdIn),
    .rs2_addr_i   (Rs2AddrIdIn),
    .rs1_re_i     (Rs1ReadEnableIn),
    .rs2_re_i     (Rs2ReadEnableIn),
    .rd_addr_i    (RdAddrIdIn),
    .rd_we_i      (RdWriteEnableIdIn),
    .is_muldiv_i  (IsMulDivIdIn),
    .mem_busy_i   (MemBusyIn),
    .issue_i      (issue),
    .md_hazard_o  (md_hazard),
    .md_busy_o    (MdBusyOut),
    .md_done_o    (MdDoneOut),
    .md_rd_addr_o (MdRdAddrOut)
  );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (MULDIV_LAT = 4). Output vector under test is
// {StallIf, StallId, BubbleEx, MdBusy, MdDone, MdRdAddr[4:0]}.
module tb_hazard_ctrl;

  logic       Clk = 1'b0;
  logic       Rst;
  logic       IssueValidIn;
  logic [4:0] Rs1AddrIdIn;
  logic [4:0] Rs2AddrIdIn;
  logic       Rs1ReadEnableIn;
  logic       Rs2ReadEnableIn;
  logic [4:0] RdAddrIdIn;
  logic       RdWriteEnableIdIn;
  logic       IsMulDivIdIn;
  logic [4:0] RdAddrExIn;
  logic       RdWriteEnableExIn;
  logic       MemReadExIn;
  logic       MemBusyIn;
  logic       FlushIn;
  logic       StallIfOut;
  logic       StallIdOut;
  logic       BubbleExOut;
  logic       MdBusyOut;
  logic       MdDoneOut;
  logic [4:0] MdRdAddrOut;

  int vecs = 0;
  int errs = 0;
  logic [9:0] exp_v;

  hazard_ctrl #(
    .MULDIV_LAT(4),
    .REG_AW    (5)
  ) dut (
    .Clk              (Clk),
    .Rst              (Rst),
    .IssueValidIn     (IssueValidIn),
    .Rs1AddrIdIn      (Rs1AddrIdIn),
    .Rs2AddrIdIn      (Rs2AddrIdIn),
    .Rs1ReadEnableIn  (Rs1ReadEnableIn),
    .Rs2ReadEnableIn  (Rs2ReadEnableIn),
    .RdAddrIdIn       (RdAddrIdIn),
    .RdWriteEnableIdIn(RdWriteEnableIdIn),
    .IsMulDivIdIn     (IsMulDivIdIn),
    .RdAddrExIn       (RdAddrExIn),
    .RdWriteEnableExIn(RdWriteEnableExIn),
    .MemReadExIn      (MemReadExIn),
    .MemBusyIn        (MemBusyIn),
    .FlushIn          (FlushIn),
    .StallIfOut       (StallIfOut),
    .StallIdOut       (StallIdOut),
    .BubbleExOut      (BubbleExOut),
    .MdBusyOut        (MdBusyOut),
    .MdDoneOut        (MdDoneOut),
    .MdRdAddrOut      (MdRdAddrOut)
  );

  always #5 Clk = ~Clk;

  function automatic logic [9:0] outs();
    return {StallIfOut, StallIdOut, BubbleExOut, MdBusyOut, MdDoneOut, MdRdAddrOut};
  endfunction

  function automatic logic [9:0] ev(logic st, logic bx, logic mb, logic md, logic [4:0] rd);
    return {st, st, bx, mb, md, rd};
  endfunction

  task automatic clear_in();
    IssueValidIn = 0; Rs1AddrIdIn = 0; Rs2AddrIdIn = 0; Rs1ReadEnableIn = 0;
    Rs2ReadEnableIn = 0; RdAddrIdIn = 0; RdWriteEnableIdIn = 0; IsMulDivIdIn = 0;
    RdAddrExIn = 0; RdWriteEnableExIn = 0; MemReadExIn = 0; MemBusyIn = 0; FlushIn = 0;
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic id_alu(logic [4:0] rs1, logic re1, logic [4:0] rs2, logic re2);
    IssueValidIn = 1; IsMulDivIdIn = 0; RdWriteEnableIdIn = 1; RdAddrIdIn = 5'd20;
    Rs1AddrIdIn = rs1; Rs1ReadEnableIn = re1; Rs2AddrIdIn = rs2; Rs2ReadEnableIn = re2;
  endtask

  task automatic id_mul(logic [4:0] rd);
    IssueValidIn = 1; IsMulDivIdIn = 1; RdWriteEnableIdIn = 1; RdAddrIdIn = rd;
    Rs1AddrIdIn = 5'd1; Rs1ReadEnableIn = 1; Rs2AddrIdIn = 5'd2; Rs2ReadEnableIn = 1;
  endtask

  task automatic ex_load(logic [4:0] rd);
    MemReadExIn = 1; RdWriteEnableExIn = 1; RdAddrExIn = rd;
  endtask

  task automatic ex_none();
    MemReadExIn = 0; RdWriteEnableExIn = 0; RdAddrExIn = 0;
  endtask

  task automatic id_none();
    IssueValidIn = 0; IsMulDivIdIn = 0; RdWriteEnableIdIn = 0; RdAddrIdIn = 0;
    Rs1ReadEnableIn = 0; Rs2ReadEnableIn = 0; Rs1AddrIdIn = 0; Rs2AddrIdIn = 0;
  endtask

  task automatic test_reset();
    clear_in();
    MemBusyIn = 1;
    Rst = 0;
    #2;
    vecs++;
    if (outs() !== 10'b0) begin
      errs++; $display("FAIL reset_outputs: got %b want %b", outs(), 10'b0);
    end
    MemBusyIn = 0;
    #10 Rst = 1;
    step();
    vecs++;
    if (outs() !== 10'b0) begin
      errs++; $display("FAIL post_reset_idle: got %b want %b", outs(), 10'b0);
    end
  endtask

  task automatic test_load_use();
    ex_load(5'd5); id_alu(5'd5, 1, 5'd3, 1);
    #1; exp_v = ev(1, 1, 0, 0, 5'd0); vecs++;
    if (outs() !== exp_v) begin
      errs++; $display("FAIL lu_rs1_stall: got %b want %b", outs(), exp_v);
    end
    step();
    ex_none();
    #1; exp_v = ev(0, 0, 0, 0, 5'd0); vecs++;
    if (outs() !== exp_v) begin
      errs++; $display("FAIL lu_release: got %b want %b", outs(), exp_v);
    end
    ex_load(5'd5); id_alu(5'd4, 1, 5'd5, 1);
    #1; exp_v = ev(1, 1, 0, 0, 5'd0); vecs++;
    if (outs() !== exp_v) begin
      errs++; $display("FAIL lu_rs2_stall: got %b want %b", outs(), exp_v);
    end
    id_alu(5'd4, 1, 5'd5, 0);
    #1; exp_v = ev(0, 0, 0, 0, 5'd0); vecs++;
    if (outs() !== exp_v) begin
      errs++; $display("FAIL lu_rs2_not_read: got %b want %b", outs(), exp_v);
    end
    step();
    ex_none(); id_none();
  endtask

  task automatic test_x0();
    ex_load(5'd0); id_alu(5'd0, 1, 5'd0, 1);
    #1; exp_v = ev(0, 0, 0, 0, 5'd0); vecs++;
    if (outs() !== exp_v) begin
      errs++; $display("FAIL x0_load_no_stall: got %b want %b", outs(), exp_v);
    end
    step();
    ex_none(); id_mul(5'd0);
    step();
    // mul to x0 in flight: a reader of x0 must not stall
    id_alu(5'd0, 1, 5'd0, 1); RdAddrIdIn = 5'd21;
    #1; exp_v = ev(0, 0, 1, 0, 5'd0); vecs++;
    if (outs() !== exp_v) begin
      errs++; $display("FAIL x0_mul_no_raw: got %b want %b", outs(), exp_v);
    end
    id_none();
    step(); step(); step();
    exp_v = ev(0, 0, 0, 1, 5'd0); vecs++;
    if (outs() !== exp_v) begin
      errs++; $display("FAIL x0_mul_done: got %b want %b", outs(), exp_v);
    end
    step();
  endtask

  task automatic test_mul_raw();
    id_mul(5'd7);
    #1; exp_v = ev(0, 0, 0, 0, 5'd0); vecs++;
    if (outs() !== exp_v) begin
      errs++; $display("FAIL mul_issue_T: got %b want %b", outs(), exp_v);
    end
    step();
    for (int c = 1; c <= 3; c++) begin
      if (c == 2) begin
        // WAW: writes x7 without reading it
        id_alu(5'd1, 0, 5'd2, 0); RdAddrIdIn = 5'd7;
      end else begin
        id_alu(5'd1, 1, 5'd7, 1);
      end
      #1; exp_v = ev(1, 1, 1, 0, 5'd7); vecs++;
      if (outs() !== exp_v) begin
        errs++; $display("FAIL mul_dep_stall_T+%0d: got %b want %b", c, outs(), exp_v);
      end
      step();
    end
    id_alu(5'd1, 1, 5'd7, 1);
    #1; exp_v = ev(0, 0, 0, 1, 5'd7); vecs++;
    if (outs() !== exp_v) begin
      errs++; $display("FAIL mul_done_T+4: got %b want %b", outs(), exp_v);
    end
    step();
    id_none();
    #1; exp_v = ev(0, 0, 0, 0, 5'd0); vecs++;
    if (outs() !== exp_v) begin
      errs++; $display("FAIL mul_idle_T+5: got %b want %b", outs(), exp_v);
    end
  endtask

  task automatic test_back_to_back();
    id_mul(5'd3);
    step();
    id_mul(5'd4);
    for (int c = 1; c <= 3; c++) begin
      #1; exp_v = ev(1, 1, 1, 0, 5'd3); vecs++;
      if (outs() !== exp_v) begin
        errs++; $display("FAIL b2b_struct_T+%0d: got %b want %b", c, outs(), exp_v);
      end
      step();
    end
    #1; exp_v = ev(0, 0, 0, 1, 5'd3); vecs++;
    if (outs() !== exp_v) begin
      errs++; $display("FAIL b2b_done_issue: got %b want %b", outs(), exp_v);
    end
    step();
    id_none();
    for (int c = 5; c <= 7; c++) begin
      #1; exp_v = ev(0, 0, 1, 0, 5'd4); vecs++;
      if (outs() !== exp_v) begin
        errs++; $display("FAIL b2b_second_busy_T+%0d: got %b want %b", c, outs(), exp_v);
      end
      step();
    end
    exp_v = ev(0, 0, 0, 1, 5'd4); vecs++;
    if (outs() !== exp_v) begin
      errs++; $display("FAIL b2b_second_done: got %b want %b", outs(), exp_v);
    end
    step();
  endtask

  task automatic test_mem_busy();
    id_mul(5'd9);
    step();
    id_none();
    for (int c = 1; c <= 7; c++) begin
      MemBusyIn = (c >= 2 && c <= 4);
      if (c == 3) begin
        ex_load(5'd6); id_alu(5'd6, 1, 5'd0, 0);
      end else begin
        ex_none(); id_none();
      end
      #1;
      if (c >= 2 && c <= 4) exp_v = ev(1, 0, 1, 0, 5'd9);
      else if (c == 7) exp_v = ev(0, 0, 0, 1, 5'd9);
      else exp_v = ev(0, 0, 1, 0, 5'd9);
      vecs++;
      if (outs() !== exp_v) begin
        errs++; $display("FAIL membusy_T+%0d: got %b want %b", c, outs(), exp_v);
      end
      step();
    end
    MemBusyIn = 0; ex_none(); id_none();
    #1; exp_v = ev(0, 0, 0, 0, 5'd0); vecs++;
    if (outs() !== exp_v) begin
      errs++; $display("FAIL membusy_idle_after: got %b want %b", outs(), exp_v);
    end
  endtask

  task automatic test_flush_and_reset();
    ex_load(5'd5); id_alu(5'd5, 1, 5'd0, 0); FlushIn = 1;
    #1; exp_v = ev(0, 0, 0, 0, 5'd0); vecs++;
    if (outs() !== exp_v) begin
      errs++; $display("FAIL flush_kills_lu: got %b want %b", outs(), exp_v);
    end
    ex_none(); id_mul(5'd12);
    step();
    FlushIn = 0; id_none();
    #1; exp_v = ev(0, 0, 0, 0, 5'd0); vecs++;
    if (outs() !== exp_v) begin
      errs++; $display("FAIL flush_blocks_issue: got %b want %b", outs(), exp_v);
    end
    id_mul(5'd11);
    step();
    id_alu(5'd11, 1, 5'd0, 0); FlushIn = 1;
    #1; exp_v = ev(0, 0, 1, 0, 5'd11); vecs++;
    if (outs() !== exp_v) begin
      errs++; $display("FAIL flush_md_hazard: got %b want %b", outs(), exp_v);
    end
    step();
    FlushIn = 0; id_none();
    step(); step();
    exp_v = ev(0, 0, 0, 1, 5'd11); vecs++;
    if (outs() !== exp_v) begin
      errs++; $display("FAIL flush_mul_completes: got %b want %b", outs(), exp_v);
    end
    step();
    id_mul(5'd13);
    step();
    id_none();
    step();
    Rst = 0;
    #1; exp_v = ev(0, 0, 0, 0, 5'd0); vecs++;
    if (outs() !== exp_v) begin
      errs++; $display("FAIL reset_mid_busy: got %b want %b", outs(), exp_v);
    end
    step();
    Rst = 1;
    for (int c = 0; c < 4; c++) begin
      #1; vecs++;
      if (outs() !== 10'b0) begin
        errs++; $display("FAIL no_done_after_reset_%0d: got %b want %b", c, outs(), 10'b0);
      end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_x0();
    test_mul_raw();
    test_back_to_back();
    test_mem_busy();
    test_flush_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Issue-side hazard controller: the counterpart of the forwarding unit.
- The forwarding unit consumes in-flight Rd results. This block decides when those results cannot yet be forwarded, and freezes IF/ID while injecting an EX bubble.
- It owns a one-deep scoreboard and latency counter for the multi-cycle mul/div unit, covering load-use, mul/div RAW/WAW, structural and memory-wait stalls.

Parameters:
- MULDIV_LAT, 4, mul/div result latency in cycles, counted from the EX-entry cycle; legal range 2..16.
- REG_AW, 5, register address width.

Ports:
- Clk  in  1  core clock.
- Rst  in  1  asynchronous, active-low reset.
- IssueValidIn  in  1  ID holds a valid instruction.
- Rs1AddrIdIn  in  REG_AW  ID rs1 address.
- Rs2AddrIdIn  in  REG_AW  ID rs2 address.
- Rs1ReadEnableIn  in  1  ID reads rs1.
- Rs2ReadEnableIn  in  1  ID reads rs2.
- RdAddrIdIn  in  REG_AW  ID destination address.
- RdWriteEnableIdIn  in  1  ID writes rd.
- IsMulDivIdIn  in  1  ID instruction is mul/div.
- RdAddrExIn  in  REG_AW  EX destination address.
- RdWriteEnableExIn  in  1  EX writes rd.
- MemReadExIn  in  1  EX instruction is a load.
- MemBusyIn  in  1  data memory not ready; whole pipe freezes.
- FlushIn  in  1  branch/exception redirect; kills IF/ID.
- StallIfOut  out  1  hold PC/IF.
- StallIdOut  out  1  hold the ID register.
- BubbleExOut  out  1  load a NOP into the ID/EX register.
- MdBusyOut  out  1  mul/div operation in flight.
- MdDoneOut  out  1  one-cycle pulse when the mul/div result is valid for writeback.
- MdRdAddrOut  out  REG_AW  destination of the in-flight mul/div.

Behaviour:
- Reset (async assert, sync release): state IDLE, counter 0, MdRdReg 0, MdWrReg 0.
  - All outputs 0 during reset.
- Source match, per source: RsN matches address X when RsNReadEnableIn is 1, RsN == X, and X != 0.
- LoadUse: IssueValidIn && MemReadExIn && RdWriteEnableExIn && RdAddrExIn != 0 && (rs1 matches RdAddrExIn || rs2 matches RdAddrExIn).
- MdHazard: IssueValidIn && state == BUSY && any of:
  - rs1 or rs2 matches MdRdReg with MdWrReg = 1 (RAW);
  - RdWriteEnableIdIn && RdAddrIdIn == MdRdReg && MdRdReg != 0 (WAW);
  - IsMulDivIdIn (structural).
- Hazard = (LoadUse || MdHazard) && !FlushIn.
- Stall and bubble outputs (combinational):
  - StallIfOut = StallIdOut = Hazard || MemBusyIn.
  - BubbleExOut = Hazard && !MemBusyIn. During MemBusyIn the whole pipe freezes, so no bubble is inserted.
- Issue = IssueValidIn && IsMulDivIdIn && !StallIdOut && !FlushIn.
- FSM:
  - IDLE:
    - On Issue: Cnt <= MULDIV_LAT-1, MdRdReg <= RdAddrIdIn, MdWrReg <= RdWriteEnableIdIn && RdAddrIdIn != 0; go to BUSY.
  - BUSY:
    - If MemBusyIn, Cnt holds.
    - Else if Cnt != 1, Cnt decrements.
    - Else (Cnt == 1), go to DONE.
  - DONE (one cycle): MdDoneOut = 1; go to IDLE.
    - The scoreboard entry clears on DONE exit; DONE itself is not BUSY, so an ID consumer may issue in the DONE cycle and takes the value through the WB forward path.
    - An Issue in the DONE cycle loads a new op exactly as from IDLE (back-to-back).
- Registered outputs:
  - MdBusyOut = (state == BUSY).
  - MdRdAddrOut = MdRdReg in BUSY/DONE, else 0.
- Latency: the mul/div result is available MULDIV_LAT cycles after the Issue cycle, excluding MemBusyIn cycles.
- FlushIn: does not cancel an in-flight mul/div, which is older than the flushed ID. It suppresses Issue and Hazard in the same cycle.
- x0 is never tracked and never causes a stall.
- Reset mid-operation: returns to IDLE immediately; no MdDoneOut pulse.

Decomposition:
- Shared package (defines):
  - REG_AW;
  - MULDIV_LAT default;
  - FSM state encodings HC_IDLE = 2'b00, HC_BUSY = 2'b01, HC_DONE = 2'b10;
  - counter width constant CNT_W = 4.
- One sub-module is natural: md_scoreboard, holding the FSM, counter, MdRdReg/MdWrReg and MdHazard compare.
- Load-use and stall muxing stay in the top level.

Test Plan:
1. Load x5 in EX (MemReadExIn = 1, RdAddrExIn = 5); ID `add` with rs1 = 5 -> StallIf/StallId/BubbleEx = 1 for exactly 1 cycle; next cycle (EX now the bubble) all 0.
2. Load to x0 in EX; ID reads x0 -> no stall.
3. MULDIV_LAT = 4: mul x7 issues at cycle T -> MdBusyOut = 1 for T+1..T+3, MdDoneOut = 1 at T+4 with MdRdAddrOut = 7. Dependent `add` rs2 = 7 stalls T+1..T+3 and issues at T+4.
4. A second mul issues while BUSY -> stalled (structural). It issues in the DONE cycle and the new BUSY starts the next cycle, with no idle gap.
5. mul x9 in flight, MemBusyIn held 3 cycles mid-count -> Cnt frozen, MdDoneOut delayed by exactly 3 cycles. BubbleExOut = 0 while MemBusyIn = 1.
6. FlushIn concurrent with a load-use hazard -> Stall/Bubble = 0; in-flight mul completes normally. Rst asserted mid-BUSY -> MdBusyOut = 0 immediately, no MdDoneOut pulse.
